// File: rtl/cache_tag_table.sv
// Direct-mapped cache tag table: per-entry coherence flag, address tag and line address,
// with one request read/write port and two combinational snoop lookup ports.
module cache_tag_table #(
  parameter int NUM_OF_ENTRY   = 1024,
  parameter int ENTRY_WIDTH    = 10,
  parameter int FLAG_WIDTH     = 2,
  parameter int ADDR_TAG_WIDTH = 18,
  parameter int ADDR_P_WIDTH   = 32,
  parameter int OFFSET_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ENTRY_WIDTH-1:0]    index,
  input  logic [ADDR_P_WIDTH-1:0]   snp_addr_1,
  input  logic [ADDR_P_WIDTH-1:0]   snp_addr_2,
  input  logic                      we_flag,
  input  logic [FLAG_WIDTH-1:0]     new_flag,
  input  logic                      we_addr,
  input  logic [ADDR_TAG_WIDTH-1:0] new_addr_tag,
  input  logic [ADDR_P_WIDTH-1:0]   new_addr_p,
  output logic                      valid,
  output logic [FLAG_WIDTH-1:0]     flag,
  output logic [ADDR_TAG_WIDTH-1:0] addr_tag,
  output logic                      snp_match_1,
  output logic [FLAG_WIDTH-1:0]     snp_flag_1,
  output logic [ENTRY_WIDTH-1:0]    snp_index_1,
  output logic                      snp_match_2,
  output logic [FLAG_WIDTH-1:0]     snp_flag_2,
  output logic [ENTRY_WIDTH-1:0]    snp_index_2
);

  localparam int LINE_WIDTH = ADDR_P_WIDTH - OFFSET_WIDTH;
  localparam logic [FLAG_WIDTH-1:0] FLAG_INVALID = '0;

  // Only the line address is kept; byte-offset bits never take part in a snoop compare.
  logic [FLAG_WIDTH-1:0]     flag_q     [NUM_OF_ENTRY];
  logic [FLAG_WIDTH-1:0]     flag_d     [NUM_OF_ENTRY];
  logic [ADDR_TAG_WIDTH-1:0] addr_tag_q [NUM_OF_ENTRY];
  logic [ADDR_TAG_WIDTH-1:0] addr_tag_d [NUM_OF_ENTRY];
  logic [LINE_WIDTH-1:0]     addr_p_q   [NUM_OF_ENTRY];
  logic [LINE_WIDTH-1:0]     addr_p_d   [NUM_OF_ENTRY];

  logic unused_offset_bits;

  always_comb begin
    flag_d     = flag_q;
    addr_tag_d = addr_tag_q;
    addr_p_d   = addr_p_q;
    if (we_flag) begin
      flag_d[index] = new_flag;
    end
    if (we_addr) begin
      addr_tag_d[index] = new_addr_tag;
      addr_p_d[index]   = new_addr_p[ADDR_P_WIDTH-1:OFFSET_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OF_ENTRY; i++) begin
        flag_q[i]     <= FLAG_INVALID;
        addr_tag_q[i] <= '0;
        addr_p_q[i]   <= '0;
      end
    end else begin
      flag_q     <= flag_d;
      addr_tag_q <= addr_tag_d;
      addr_p_q   <= addr_p_d;
    end
  end

  // Request port: reads are from the registered state, so a write shows up after the edge.
  assign flag     = flag_q[index];
  assign addr_tag = addr_tag_q[index];
  assign valid    = (flag != FLAG_INVALID);

  assign snp_index_1 = snp_addr_1[OFFSET_WIDTH +: ENTRY_WIDTH];
  assign snp_flag_1  = flag_q[snp_index_1];
  assign snp_match_1 = (snp_flag_1 != FLAG_INVALID) &&
                       (addr_p_q[snp_index_1] == snp_addr_1[ADDR_P_WIDTH-1:OFFSET_WIDTH]);

  assign snp_index_2 = snp_addr_2[OFFSET_WIDTH +: ENTRY_WIDTH];
  assign snp_flag_2  = flag_q[snp_index_2];
  assign snp_match_2 = (snp_flag_2 != FLAG_INVALID) &&
                       (addr_p_q[snp_index_2] == snp_addr_2[ADDR_P_WIDTH-1:OFFSET_WIDTH]);

  assign unused_offset_bits = ^{snp_addr_1[OFFSET_WIDTH-1:0], snp_addr_2[OFFSET_WIDTH-1:0],
                                new_addr_p[OFFSET_WIDTH-1:0]};

endmodule

// File: tb/tb_cache_tag_table.sv
// Directed table-driven bench for cache_tag_table at default parameters: each record drives
// one cycle of inputs and lists the outputs expected just before that cycle's rising edge.
module tb_cache_tag_table;

  logic        clk;
  logic        rst;
  logic [9:0]  index;
  logic [31:0] snp_addr_1, snp_addr_2;
  logic        we_flag, we_addr;
  logic [1:0]  new_flag;
  logic [17:0] new_addr_tag;
  logic [31:0] new_addr_p;
  logic        valid;
  logic [1:0]  flag;
  logic [17:0] addr_tag;
  logic        snp_match_1, snp_match_2;
  logic [1:0]  snp_flag_1, snp_flag_2;
  logic [9:0]  snp_index_1, snp_index_2;

  int checks = 0;
  int errors = 0;

  cache_tag_table dut (
    .clk(clk), .rst(rst), .index(index),
    .snp_addr_1(snp_addr_1), .snp_addr_2(snp_addr_2),
    .we_flag(we_flag), .new_flag(new_flag),
    .we_addr(we_addr), .new_addr_tag(new_addr_tag), .new_addr_p(new_addr_p),
    .valid(valid), .flag(flag), .addr_tag(addr_tag),
    .snp_match_1(snp_match_1), .snp_flag_1(snp_flag_1), .snp_index_1(snp_index_1),
    .snp_match_2(snp_match_2), .snp_flag_2(snp_flag_2), .snp_index_2(snp_index_2)
  );

  // clock / reset block: reset itself is the first table record
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        we_flag;
    logic        we_addr;
    logic [9:0]  index;
    logic [1:0]  new_flag;
    logic [17:0] new_tag;
    logic [31:0] new_p;
    logic [31:0] snp1;
    logic [31:0] snp2;
    logic        e_valid;
    logic [1:0]  e_flag;
    logic [17:0] e_tag;
    logic        e_m1;
    logic [1:0]  e_f1;
    logic [9:0]  e_i1;
    logic        e_m2;
    logic [1:0]  e_f2;
    logic [9:0]  e_i2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int chk, input int r, input int wf, input int wa, input int idx,
                     input int nf, input int nt, input int np, input int s1, input int s2,
                     input int ev, input int ef, input int et, input int m1, input int f1,
                     input int i1, input int m2, input int f2, input int i2);
    vec_t v;
    v.chk = 1'(chk);  v.rst = 1'(r);  v.we_flag = 1'(wf);  v.we_addr = 1'(wa);
    v.index = 10'(idx);  v.new_flag = 2'(nf);  v.new_tag = 18'(nt);  v.new_p = 32'(np);
    v.snp1 = 32'(s1);  v.snp2 = 32'(s2);
    v.e_valid = 1'(ev);  v.e_flag = 2'(ef);  v.e_tag = 18'(et);
    v.e_m1 = 1'(m1);  v.e_f1 = 2'(f1);  v.e_i1 = 10'(i1);
    v.e_m2 = 1'(m2);  v.e_f2 = 2'(f2);  v.e_i2 = 10'(i2);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;  we_flag = v.we_flag;  we_addr = v.we_addr;  index = v.index;
    new_flag = v.new_flag;  new_addr_tag = v.new_tag;  new_addr_p = v.new_p;
    snp_addr_1 = v.snp1;  snp_addr_2 = v.snp2;
  endtask

  task automatic check_vec(input int n, input vec_t v);
    string p;
    p = $sformatf("v%0d", n);
    check({p, ".valid"},    32'(valid),       32'(v.e_valid));
    check({p, ".flag"},     32'(flag),        32'(v.e_flag));
    check({p, ".addr_tag"}, 32'(addr_tag),    32'(v.e_tag));
    check({p, ".match1"},   32'(snp_match_1), 32'(v.e_m1));
    check({p, ".sflag1"},   32'(snp_flag_1),  32'(v.e_f1));
    check({p, ".sidx1"},    32'(snp_index_1), 32'(v.e_i1));
    check({p, ".match2"},   32'(snp_match_2), 32'(v.e_m2));
    check({p, ".sflag2"},   32'(snp_flag_2),  32'(v.e_f2));
    check({p, ".sidx2"},    32'(snp_index_2), 32'(v.e_i2));
  endtask

  initial begin
    logic [31:0] s1, s2;
    rst = 1'b1;  we_flag = 1'b0;  we_addr = 1'b0;  index = '0;  new_flag = '0;
    new_addr_tag = '0;  new_addr_p = '0;  snp_addr_1 = '0;  snp_addr_2 = '0;

    //  chk rst wf wa idx    nf nt       np          s1          s2        | ev ef et      m1 f1 i1     m2 f2 i2
    add(0,  1,  1, 1, 0,     3, 'h2CC,   'hDDD,      0,          0,          0, 0, 0,       0, 0, 0,     0, 0, 0);
    add(1,  0,  0, 0, 0,     0, 0,       0,          'hDDD,      0,          0, 0, 0,       0, 0, 'h377, 0, 0, 0);
    add(1,  0,  1, 1, 0,     3, 'h2CC,   'hDDD,      0,          0,          0, 0, 0,       0, 0, 0,     0, 0, 0);
    add(1,  0,  0, 0, 0,     0, 0,       0,          'hDDD,      0,          1, 3, 'h2CC,   0, 0, 'h377, 0, 3, 0);
    add(1,  0,  1, 1, 'h377, 3, 'h155,   'hDDC,      'hDDF,      'hDDD,      0, 0, 0,       0, 0, 'h377, 0, 0, 'h377);
    add(1,  0,  0, 0, 'h377, 0, 0,       0,          'hDDF,      'hDDD,      1, 3, 'h155,   1, 3, 'h377, 1, 3, 'h377);
    add(1,  0,  1, 0, 'h377, 0, 'h3FFFF, 'hFFFFFFFF, 'h1DDC,     'hDDC,      1, 3, 'h155,   0, 3, 'h377, 1, 3, 'h377);
    add(1,  0,  0, 0, 'h377, 0, 0,       0,          'hDDC,      'hDDC,      0, 0, 'h155,   0, 0, 'h377, 0, 0, 'h377);
    add(1,  0,  1, 1, 5,     1, 'h0AB,   'hABC014,   'hABC014,   'hABC016,   0, 0, 0,       0, 0, 5,     0, 0, 5);
    add(1,  0,  0, 0, 6,     0, 0,       0,          'hABC017,   'h18,       0, 0, 0,       1, 1, 5,     0, 0, 6);
    add(1,  0,  0, 1, 5,     2, 'h3FFFF, 'h123014,   'hABC014,   'hABD014,   1, 1, 'h0AB,   1, 1, 5,     0, 1, 5);
    add(1,  0,  0, 0, 5,     0, 0,       0,          'h123015,   'hABC014,   1, 1, 'h3FFFF, 1, 1, 5,     0, 1, 5);
    add(1,  1,  1, 1, 5,     3, 'h111,   'h123014,   'h123015,   'hABC014,   1, 1, 'h3FFFF, 1, 1, 5,     0, 1, 5);
    add(1,  0,  0, 0, 5,     0, 0,       0,          'h123015,   'hDDC,      0, 0, 0,       0, 0, 5,     0, 0, 'h377);
    add(1,  0,  0, 0, 'h377, 0, 0,       0,          'hDDF,      0,          0, 0, 0,       0, 0, 'h377, 0, 0, 0);
    add(1,  0,  0, 0, 0,     0, 0,       0,          'hDDD,      'hDDC,      0, 0, 0,       0, 0, 'h377, 0, 0, 'h377);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      if (vecs[i].chk) check_vec(i, vecs[i]);
    end

    // after reset every lookup reads empty whatever the address
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0;  we_flag = 1'b0;  we_addr = 1'b0;
      index = 10'($urandom_range(0, 1023));
      s1 = $urandom;  s2 = $urandom;
      snp_addr_1 = s1;  snp_addr_2 = s2;
      #1;
      check("rand.valid",  32'(valid),       32'(0));
      check("rand.flag",   32'(flag),        32'(0));
      check("rand.tag",    32'(addr_tag),    32'(0));
      check("rand.match1", 32'(snp_match_1), 32'(0));
      check("rand.sflag1", 32'(snp_flag_1),  32'(0));
      check("rand.sidx1",  32'(snp_index_1), 32'(s1[11:2]));
      check("rand.match2", 32'(snp_match_2), 32'(0));
      check("rand.sflag2", 32'(snp_flag_2),  32'(0));
      check("rand.sidx2",  32'(snp_index_2), 32'(s2[11:2]));
    end

    // new contents must be visible right after the write edge
    @(negedge clk);
    index = 10'h0C3;  we_flag = 1'b1;  we_addr = 1'b1;  new_flag = 2'd2;
    new_addr_tag = 18'h1234;  new_addr_p = 32'h0000_030C;
    snp_addr_1 = 32'h0000_030E;  snp_addr_2 = 32'h0000_030C;
    @(posedge clk);
    #1;
    we_flag = 1'b0;  we_addr = 1'b0;
    #1;
    check("lat.valid",  32'(valid),       32'(1));
    check("lat.flag",   32'(flag),        32'(2));
    check("lat.tag",    32'(addr_tag),    32'(18'h1234));
    check("lat.match1", 32'(snp_match_1), 32'(1));
    check("lat.sidx1",  32'(snp_index_1), 32'(10'h0C3));
    check("lat.match2", 32'(snp_match_2), 32'(1));
    check("lat.sflag2", 32'(snp_flag_2),  32'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_tag_table.md
CACHE_TAG_TABLE -- requirements
Module: cache_tag_table

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_OF_ENTRY, default 1024, SHALL set the number of table entries.
REQ-003 Parameter ENTRY_WIDTH, default 10, SHALL set the index width (log2 of NUM_OF_ENTRY).
REQ-004 Parameter FLAG_WIDTH, default 2, SHALL set the coherence flag width.
REQ-005 Parameter ADDR_TAG_WIDTH, default 18, SHALL set the address tag width.
REQ-006 Parameter ADDR_P_WIDTH, default 32, SHALL set the physical address width.
REQ-007 Parameter OFFSET_WIDTH, default 2, SHALL set the byte-offset width within a line.
REQ-008 Port clk, input, 1 bit, SHALL be the clock; all state changes occur on its rising edge.
REQ-009 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-010 Port index, input, ENTRY_WIDTH, SHALL be the CPU/MEM request entry index.
REQ-011 Ports snp_addr_1 and snp_addr_2, input, ADDR_P_WIDTH each, SHALL be the snoop physical addresses from the L1-L2 bus and the L2-MEM bus.
REQ-012 Port we_flag, input, 1 bit, SHALL be the flag write enable.
REQ-013 Port new_flag, input, FLAG_WIDTH, SHALL be the flag value to write.
REQ-014 Port we_addr, input, 1 bit, SHALL be the address write enable.
REQ-015 Port new_addr_tag, input, ADDR_TAG_WIDTH, SHALL be the tag value to write.
REQ-016 Port new_addr_p, input, ADDR_P_WIDTH, SHALL be the physical address value to write.
REQ-017 Port valid, output, 1 bit, SHALL indicate that the indexed entry is not INVALID.
REQ-018 Ports flag (FLAG_WIDTH) and addr_tag (ADDR_TAG_WIDTH), outputs, SHALL be the indexed entry's flag and tag.
REQ-019 Ports snp_match_1/2 (1 bit), snp_flag_1/2 (FLAG_WIDTH) and snp_index_1/2 (ENTRY_WIDTH), outputs, SHALL be the per-bus snoop hit, flag and entry index.

Function
REQ-020 Flag encoding SHALL be: INVALID=0, SHARED_CLEAN=1, OWNED_CLEAN=2, OWNED_DIRTY=3.
REQ-021 Each entry SHALL store a flag, an addr_tag and an addr_p.
REQ-022 valid, flag and addr_tag SHALL be combinational reads of entry[index], with valid = (flag != INVALID).
REQ-023 On a rising edge with we_flag=1 and rst=0, flag[index] SHALL be loaded with new_flag.
REQ-024 On a rising edge with we_addr=1 and rst=0, addr_tag[index] and addr_p[index] SHALL be loaded with new_addr_tag and new_addr_p.
REQ-025 we_flag and we_addr SHALL act independently; when both are 1, both updates SHALL occur in the same cycle.
REQ-026 During the write cycle, outputs SHALL show the old contents; new contents SHALL appear immediately after the edge (1-cycle write latency, 0-cycle read latency).
REQ-027 For each snoop bus n, snp_index_n SHALL equal snp_addr_n[OFFSET_WIDTH+ENTRY_WIDTH-1 : OFFSET_WIDTH], i.e. bits [11:2] at the defaults.
REQ-028 snp_flag_n SHALL equal flag[snp_index_n], combinationally.
REQ-029 snp_match_n SHALL be 1 iff flag[snp_index_n] != INVALID and addr_p[snp_index_n] equals snp_addr_n above bit OFFSET_WIDTH-1; offset bits SHALL be ignored.
REQ-030 Both snoop ports and the request port SHALL be usable simultaneously, including on the same entry.
REQ-031 A snoop address hitting the entry being written SHALL reflect pre-write contents in that cycle.

Reset
REQ-032 A rising edge with rst=1 SHALL set every flag to INVALID and every addr_tag and addr_p to 0.
REQ-033 rst SHALL override we_flag and we_addr in the same cycle.
REQ-034 After reset, valid=0, flag=0, addr_tag=0, snp_match_1/2=0 and snp_flag_1/2=0 for every input value.

Verification
REQ-035 Reset, then index=0, we_flag=we_addr=1 for one cycle with new_flag=3, new_addr_tag=0x2CC, new_addr_p=0xDDD -> after the edge valid=1, flag=3, addr_tag=0x2CC; before the edge valid=0.
REQ-036 Write index=0x377 with flag=3 and addr_p=0xDDC; drive snp_addr_1=0xDDF and snp_addr_2=0xDDD -> both snp_match=1, snp_flag=3, snp_index=0x377.
REQ-037 Same entry, snp_addr_1=0x1DDC -> snp_index_1=0x377, snp_match_1=0, snp_flag_1=3.
REQ-038 we_flag=1 alone with new_flag=0 on index 0x377 -> valid=0, addr_tag unchanged, snp_match on 0xDDC=0.
REQ-039 Assert rst and we_flag=we_addr=1 together -> all entries read INVALID/0 after the edge.
REQ-040 Write at index 5 -> index 6 remains valid=0 and unchanged.
